// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the programmable clock-pattern generator.
package clk_gen_pkg;

  localparam int unsigned LfsrW = 16;
  localparam logic [LfsrW-1:0] LfsrTaps = 16'hB400;

  // Config fields are stored at this width; the top's CNT_W must not exceed it.
  localparam int unsigned CfgW = 16;

  localparam logic [1:0] StOff  = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;

  typedef struct packed {
    logic [CfgW-1:0] period;
    logic [CfgW-1:0] high;
    logic [2:0]      jit;
  } cfg_t;

  // Low J bits of the LFSR read as a two's-complement offset; zero when J is 0.
  function automatic logic signed [7:0] jit_offset(input logic [LfsrW-1:0] lfsr,
                                                   input logic [2:0]       jit);
    logic [7:0] mask;
    logic [7:0] val;
    mask = (8'd1 << jit) - 8'd1;
    val  = lfsr[7:0] & mask;
    if (jit != 3'd0 && lfsr[jit-3'd1]) begin
      val = val - (8'd1 << jit);
    end
    return $signed(val);
  endfunction

endpackage

// File: rtl/clk_gen_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that steps once per advance strobe.
module clk_gen_lfsr
  import clk_gen_pkg::*;
#(
  parameter logic [LfsrW-1:0] Seed = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  output logic [LfsrW-1:0] value_o
);

  logic [LfsrW-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable clock-pattern generator: period/high/jitter config applied at period boundaries.
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int unsigned      CNT_W     = 16,
  parameter logic [LfsrW-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [2:0]       cfg_jit,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_start,
  output logic             running
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic             clk_out_q, clk_out_d;
  logic             period_start_q, period_start_d;
  logic             cfg_err_q, cfg_err_d;
  cfg_t             pend_q, pend_d, act_q, act_d;
  logic             pend_valid_q, pend_valid_d;
  logic             act_valid_q, act_valid_d;

  logic [LfsrW-1:0] lfsr_val;
  logic             lfsr_adv;
  logic             start;
  logic             cfg_bad;
  logic [CNT_W:0]   in_gap, in_half;
  cfg_t             cur_cfg;
  logic [CNT_W-1:0] cur_period, cur_high;

  clk_gen_lfsr #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_i   (rst),
    .adv_i   (lfsr_adv),
    .value_o (lfsr_val)
  );

  // Jittered low time must stay >= 1, so the gap has to exceed the largest negative offset.
  always_comb begin
    in_gap  = {1'b0, cfg_period} - {1'b0, cfg_high};
    in_half = (CNT_W+1)'(1) << (cfg_jit - 3'd1);
    cfg_bad = (cfg_high == '0) || (cfg_high >= cfg_period) ||
              ((cfg_jit != 3'd0) && (in_gap <= in_half));
  end

  // A new period always uses the pending config if one was waiting at the boundary.
  always_comb begin
    cur_cfg    = pend_valid_q ? pend_q : act_q;
    cur_period = CNT_W'(cur_cfg.period);
    cur_high   = CNT_W'(cur_cfg.high);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    low_len_d      = low_len_q;
    clk_out_d      = clk_out_q;
    period_start_d = 1'b0;
    cfg_err_d      = 1'b0;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    act_d          = act_q;
    act_valid_d    = act_valid_q;
    lfsr_adv       = 1'b0;
    start          = 1'b0;

    case (state_q)
      StOff: begin
        if (en && (act_valid_q || pend_valid_q)) begin
          start = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = StLow;
          clk_out_d = 1'b0;
          cnt_d     = low_len_q - 1'b1;
        end
      end
      StLow: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (en) begin
          start = 1'b1;
        end else begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase

    if (start) begin
      if (pend_valid_q) begin
        act_d        = pend_q;
        act_valid_d  = 1'b1;
        pend_valid_d = 1'b0;
      end
      state_d        = StHigh;
      clk_out_d      = 1'b1;
      period_start_d = 1'b1;
      cnt_d          = cur_high - 1'b1;
      // Low time is fixed for the whole period from the LFSR value at its start.
      low_len_d      = cur_period - cur_high + CNT_W'(jit_offset(lfsr_val, cur_cfg.jit));
      lfsr_adv       = 1'b1;
    end

    // Transfer only when pending is empty, so it never collides with promotion above.
    if (cfg_valid && !pend_valid_q) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_d.period = CfgW'(cfg_period);
        pend_d.high   = CfgW'(cfg_high);
        pend_d.jit    = cfg_jit;
        pend_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StOff;
      cnt_q          <= '0;
      low_len_q      <= '0;
      clk_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      act_q          <= '0;
      act_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      low_len_q      <= low_len_d;
      clk_out_q      <= clk_out_d;
      period_start_q <= period_start_d;
      cfg_err_q      <= cfg_err_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      act_q          <= act_d;
      act_valid_q    <= act_valid_d;
    end
  end

  assign cfg_ready    = !pend_valid_q;
  assign cfg_err      = cfg_err_q;
  assign clk_out      = clk_out_q;
  assign period_start = period_start_q;
  assign running      = (state_q != StOff);

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Bench for clk_gen_ctrl: waveform-queue model checked every cycle plus directed literal checks.
module tb_clk_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [2:0]  cfg_jit = '0;
  logic        cfg_err;
  logic        clk_out;
  logic        period_start;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  clk_gen_ctrl #(
    .CNT_W     (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_jit      (cfg_jit),
    .cfg_err      (cfg_err),
    .clk_out      (clk_out),
    .period_start (period_start),
    .running      (running)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #3000000;
    $display("FAIL watchdog: got time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d (0x%0h), required %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int p; int h; int j;} mcfg_t;

  function automatic bit [15:0] ref_next(input bit [15:0] l);
    bit fb;
    fb = l[0];
    l  = l >> 1;
    if (fb) l = l ^ 16'hB400;
    return l;
  endfunction

  function automatic int ref_off(input bit [15:0] l, input int j);
    int v;
    if (j == 0) return 0;
    v = int'(l) % (1 << j);
    if (v >= (1 << (j - 1))) v = v - (1 << j);
    return v;
  endfunction

  function automatic bit ref_legal(input int p, input int h, input int j);
    if (h == 0 || h >= p) return 0;
    if (j > 0 && (p - h) <= (1 << (j - 1))) return 0;
    return 1;
  endfunction

  mcfg_t     m_act, m_pend;
  bit        m_act_v, m_pend_v;
  bit        m_wave[$];
  bit [15:0] m_lfsr;
  bit        e_clk, e_ps, e_run, e_ready, e_err;

  // Model: each started period is laid out as H ones followed by the low-time zeros.
  initial begin
    int off;
    bit old_pend;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act_v = 0; m_pend_v = 0; m_wave.delete(); m_lfsr = 16'hACE1;
        e_clk = 0; e_ps = 0; e_run = 0; e_ready = 1; e_err = 0;
        chk_en = 1;
      end else begin
        old_pend = m_pend_v;
        e_ps = 0;
        e_err = 0;
        if (m_wave.size() == 0 && en && (m_act_v || m_pend_v)) begin
          if (m_pend_v) begin m_act = m_pend; m_act_v = 1; m_pend_v = 0; end
          off = ref_off(m_lfsr, m_act.j);
          m_lfsr = ref_next(m_lfsr);
          repeat (m_act.h) m_wave.push_back(1'b1);
          repeat (m_act.p - m_act.h + off) m_wave.push_back(1'b0);
          e_ps = 1;
        end
        if (m_wave.size() > 0) begin
          e_clk = m_wave.pop_front();
          e_run = 1;
        end else begin
          e_clk = 0;
          e_run = 0;
        end
        if (cfg_valid && !old_pend) begin
          if (ref_legal(int'(cfg_period), int'(cfg_high), int'(cfg_jit))) begin
            m_pend.p = int'(cfg_period);
            m_pend.h = int'(cfg_high);
            m_pend.j = int'(cfg_jit);
            m_pend_v = 1;
          end else begin
            e_err = 1;
          end
        end
        e_ready = !m_pend_v;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cycle outputs {clk_out,period_start,running,cfg_ready,cfg_err}",
            {27'd0, clk_out, period_start, running, cfg_ready, cfg_err},
            {27'd0, e_clk, e_ps, e_run, e_ready, e_err});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; cfg_valid = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic offer(input int p, input int h, input int j);
    int k;
    k = 0;
    cfg_period = 16'(p); cfg_high = 16'(h); cfg_jit = 3'(j); cfg_valid = 1;
    while (cfg_ready !== 1'b1 && k < 1000) begin tick(1); k++; end
    tick(1);
    cfg_valid = 0;
    check("offer transferred within bound", {31'd0, k < 1000}, 1);
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    while (period_start !== 1'b1 && k < 1000) begin tick(1); k++; end
    check("period_start within bound", {31'd0, k < 1000}, 1);
  endtask

  // Called in a period_start cycle; returns in the next period_start cycle.
  task automatic measure(output int hi, output int lo);
    hi = 0; lo = 0;
    while (clk_out === 1'b1 && hi < 1000) begin hi++; tick(1); end
    while (clk_out === 1'b0 && lo < 1000) begin lo++; tick(1); end
    check("measure within bound", {31'd0, hi < 1000 && lo < 1000}, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int hi, lo, ps0, n;
    int lows[4];
    bit [7:0] seen;

    // Reset values, then P=10 H=3 J=0.
    do_reset();
    check("reset clk_out", clk_out, 0);
    check("reset period_start", period_start, 0);
    check("reset running", running, 0);
    check("reset cfg_err", cfg_err, 0);
    check("reset cfg_ready", cfg_ready, 1);
    offer(10, 3, 0);
    check("cfg_ready low after accept", cfg_ready, 0);
    check("stays off while en=0", running, 0);
    en = 1;
    check("clk_out low in en cycle", clk_out, 0);
    tick(1);
    check("first rise one cycle after en", clk_out, 1);
    check("period_start on first rise", period_start, 1);
    check("cfg_ready back after promotion", cfg_ready, 1);
    repeat (2) begin
      measure(hi, lo);
      check("P10H3 high", hi, 3);
      check("P10H3 low", lo, 7);
    end

    // Reconfigure mid-HIGH: current period completes, then 2/4.
    ps0 = cyc;
    cfg_period = 16'd6; cfg_high = 16'd2; cfg_jit = 3'd0; cfg_valid = 1;
    tick(1);
    cfg_valid = 0;
    check("pending full mid-period", cfg_ready, 0);
    wait_ps();
    check("old period completes", cyc - ps0, 10);
    check("cfg_ready at boundary", cfg_ready, 1);
    measure(hi, lo);
    check("P6H2 high", hi, 2);
    check("P6H2 low", lo, 4);

    // Rejected configs.
    offer(10, 0, 0);
    check("reject H=0 err", cfg_err, 1);
    check("reject H=0 ready", cfg_ready, 1);
    offer(8, 8, 0);
    check("reject H>=P err", cfg_err, 1);
    offer(10, 7, 3);
    check("reject jitter gap err", cfg_err, 1);
    check("reject jitter gap ready", cfg_ready, 1);
    wait_ps();
    measure(hi, lo);
    check("after rejects high", hi, 2);
    check("after rejects low", lo, 4);

    // en drops in the 2nd HIGH cycle.
    do_reset();
    offer(10, 3, 0);
    en = 1;
    tick(1);
    tick(1);
    en = 0;
    n = 0;
    while (running === 1'b1 && n < 100) begin n++; tick(1); end
    check("period completes after en drop", n, 9);
    check("clk_out low when off", clk_out, 0);
    tick(3);
    check("stays off", running, 0);
    en = 1;
    tick(1);
    check("restart period_start", period_start, 1);

    // Reset during LOW clears everything including the config.
    n = 0;
    while (!(clk_out === 1'b0 && running === 1'b1) && n < 100) begin n++; tick(1); end
    rst = 1;
    tick(1);
    check("mid-reset clk_out", clk_out, 0);
    check("mid-reset period_start", period_start, 0);
    check("mid-reset running", running, 0);
    check("mid-reset cfg_err", cfg_err, 0);
    check("mid-reset cfg_ready", cfg_ready, 1);
    rst = 0;
    tick(5);
    check("no config after reset", running, 0);
    check("no config clk_out", clk_out, 0);

    // Jitter P=20 H=5 J=3 over 2000 periods.
    do_reset();
    offer(20, 5, 3);
    en = 1;
    tick(1);
    seen = '0;
    for (int i = 0; i < 2000; i++) begin
      measure(hi, lo);
      check("jitter high exact", hi, 5);
      check("jitter low in [11,18]", {31'd0, lo >= 11 && lo <= 18}, 1);
      if (lo >= 11 && lo <= 18) seen[lo-11] = 1'b1;
      if (i < 4) lows[i] = lo;
    end
    check("all 8 low values seen", seen, 8'hFF);
    check("jitter low #0 (seed 0xACE1)", lows[0], 16);
    check("jitter low #1 (0xE270)", lows[1], 15);
    check("jitter low #2 (0x7138)", lows[2], 15);
    check("jitter low #3 (0x389C)", lows[3], 11);

    // Fastest toggle.
    do_reset();
    offer(2, 1, 0);
    en = 1;
    tick(1);
    repeat (3) begin
      measure(hi, lo);
      check("P2H1 high", hi, 1);
      check("P2H1 low", lo, 1);
    end

    // Back-pressure: second offer waits while pending is full, then applies next.
    do_reset();
    offer(10, 3, 0);
    cfg_period = 16'd6; cfg_high = 16'd2; cfg_jit = 3'd0; cfg_valid = 1;
    en = 1;
    check("back-pressured ready", cfg_ready, 0);
    tick(1);
    ps0 = cyc;
    check("first period starts", period_start, 1);
    tick(1);
    cfg_valid = 0;
    check("held offer now pending", cfg_ready, 0);
    wait_ps();
    check("held period length", cyc - ps0, 10);
    measure(hi, lo);
    check("held config high", hi, 2);
    check("held config low", lo, 4);

    en = 0;
    tick(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
